// File: rtl/invsqrt_pkg.sv
// Shared types and FP32 constants for the inverse-square-root sequencer.
package invsqrt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_INIT,
    S_SQ,
    S_HX,
    S_SUB,
    S_UPD,
    S_DONE
  } state_e;

  typedef enum logic {
    OP_MUL  = 1'b0,
    OP_RSUB = 1'b1
  } fpu_op_e;

  localparam logic [31:0] FP_THREE_HALVES = 32'h3FC0_0000;
  localparam logic [31:0] FP_POS_INF      = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;
  localparam logic [31:0] FP_MAGIC        = 32'h5F37_59DF;

  function automatic logic [7:0] fp_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

endpackage

// File: rtl/invsqrt_classify.sv
// Flags operands whose reciprocal square root is a fixed special value.
module invsqrt_classify
  import invsqrt_pkg::*;
(
  input  logic [31:0] x_i,
  output logic        is_special_o,
  output logic [31:0] special_value_o
);

  logic [7:0] exp_w;

  assign exp_w = fp_exp(x_i);

  // Zero/denormal takes priority, so -0 also maps to +inf.
  always_comb begin
    is_special_o    = 1'b1;
    special_value_o = FP_QNAN;
    if (exp_w == 8'h00) begin
      special_value_o = FP_POS_INF;
    end else if (x_i[31]) begin
      special_value_o = FP_QNAN;
    end else if (exp_w == 8'hFF) begin
      special_value_o = (x_i[22:0] == 23'd0) ? 32'h0000_0000 : FP_QNAN;
    end else begin
      is_special_o    = 1'b0;
      special_value_o = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/invsqrt_seq_ctrl.sv
// Sequences magic-constant init plus ITER Newton steps on a shared external FPU.
// IDLE accept | INIT init stage loads | WAIT_INIT capture y,hx | SQ t=y*y
// HX t=hx*t | SUB t=1.5-t | UPD y=y*t | DONE hold result until out_ready
module invsqrt_seq_ctrl
  import invsqrt_pkg::*;
#(
  parameter int unsigned ITER         = 2,
  parameter logic [31:0] THREE_HALVES = FP_THREE_HALVES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [31:0] init_data,
  input  logic [31:0] init_y,
  input  logic [31:0] init_half,
  output logic        fpu_valid,
  output logic        fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result,
  input  logic        fpu_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_exc,
  output logic        busy
);

  localparam logic [2:0] ITER_C = 3'(ITER);

  state_e      state_q;
  logic [31:0] y_q;
  logic [31:0] hx_q;
  logic [31:0] t_q;
  logic [2:0]  cnt_q;
  logic        fpu_valid_q;
  logic        out_valid_q;
  logic        out_exc_q;
  logic [31:0] out_data_q;
  logic [31:0] init_data_q;

  logic        is_special;
  logic [31:0] special_value;
  logic        op_ack;
  fpu_op_e     op_sel;
  logic [31:0] a_sel;
  logic [31:0] b_sel;

  invsqrt_classify u_classify (
    .x_i             (in_data),
    .is_special_o    (is_special),
    .special_value_o (special_value)
  );

  // A done coincident with the issue pulse cannot belong to this op.
  assign op_ack = fpu_done && !fpu_valid_q;

  // Operands come straight from registers that only change on op completion.
  always_comb begin
    op_sel = OP_MUL;
    a_sel  = 32'h0000_0000;
    b_sel  = 32'h0000_0000;
    case (state_q)
      S_SQ: begin
        a_sel = y_q;
        b_sel = y_q;
      end
      S_HX: begin
        a_sel = hx_q;
        b_sel = t_q;
      end
      S_SUB: begin
        op_sel = OP_RSUB;
        a_sel  = THREE_HALVES;
        b_sel  = t_q;
      end
      S_UPD: begin
        a_sel = y_q;
        b_sel = t_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      y_q         <= 32'h0000_0000;
      hx_q        <= 32'h0000_0000;
      t_q         <= 32'h0000_0000;
      cnt_q       <= 3'd0;
      fpu_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_exc_q   <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      init_data_q <= 32'h0000_0000;
    end else begin
      fpu_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            init_data_q <= in_data;
            if (is_special) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= special_value;
              out_exc_q   <= 1'b1;
            end else begin
              state_q <= S_INIT;
            end
          end
        end
        S_INIT: state_q <= S_WAIT_INIT;
        S_WAIT_INIT: begin
          y_q   <= init_y;
          hx_q  <= init_half;
          cnt_q <= 3'd0;
          if (ITER_C == 3'd0) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= init_y;
            out_exc_q   <= 1'b0;
          end else begin
            state_q     <= S_SQ;
            fpu_valid_q <= 1'b1;
          end
        end
        S_SQ: begin
          if (op_ack) begin
            t_q         <= fpu_result;
            state_q     <= S_HX;
            fpu_valid_q <= 1'b1;
          end
        end
        S_HX: begin
          if (op_ack) begin
            t_q         <= fpu_result;
            state_q     <= S_SUB;
            fpu_valid_q <= 1'b1;
          end
        end
        S_SUB: begin
          if (op_ack) begin
            t_q         <= fpu_result;
            state_q     <= S_UPD;
            fpu_valid_q <= 1'b1;
          end
        end
        S_UPD: begin
          if (op_ack) begin
            y_q   <= fpu_result;
            cnt_q <= cnt_q + 3'd1;
            if ((cnt_q + 3'd1) == ITER_C) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= fpu_result;
              out_exc_q   <= 1'b0;
            end else begin
              state_q     <= S_SQ;
              fpu_valid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign init_data = init_data_q;
  assign fpu_valid = fpu_valid_q;
  assign fpu_op    = op_sel;
  assign fpu_a     = a_sel;
  assign fpu_b     = b_sel;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_exc   = out_exc_q;

endmodule

// File: tb/tb_invsqrt_seq_ctrl.sv
// Scoreboard bench: directed requests, a latency-2 FPU model and an output monitor.
module tb_invsqrt_seq_ctrl;
  import invsqrt_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        exc;
    int          tol;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_exc, busy;
  logic [31:0] in_data = '0, init_data, init_y, init_half, out_data;
  logic        fpu_valid, fpu_op, fpu_done, fpu_done_m = 1'b0, spur_done = 1'b0;
  logic [31:0] fpu_a, fpu_b, fpu_result = '0;

  logic        in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1, out_exc0, busy0;
  logic [31:0] in_data0 = '0, init_data0, init_y0, init_half0, out_data0;
  logic        fpu_valid0, fpu_op0;
  logic        fpu_done0 = 1'b0;
  logic [31:0] fpu_a0, fpu_b0;
  logic [31:0] fpu_result0 = '0;

  int n_cmp = 0;
  int n_err = 0;
  int n_ops = 0;
  int n_ops0 = 0;
  exp_t exp_q[$];
  exp_t exp0_q[$];

  assign fpu_done = fpu_done_m | spur_done;

  always #5 clk = ~clk;

  invsqrt_seq_ctrl #(.ITER(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .init_data(init_data), .init_y(init_y), .init_half(init_half),
    .fpu_valid(fpu_valid), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result), .fpu_done(fpu_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc),
    .busy(busy)
  );

  invsqrt_seq_ctrl #(.ITER(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .init_data(init_data0), .init_y(init_y0), .init_half(init_half0),
    .fpu_valid(fpu_valid0), .fpu_op(fpu_op0), .fpu_a(fpu_a0), .fpu_b(fpu_b0),
    .fpu_result(fpu_result0), .fpu_done(fpu_done0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_exc(out_exc0),
    .busy(busy0)
  );

  function automatic logic [31:0] f_half(input logic [31:0] x);
    return {x[31], x[30:23] - 8'd1, x[22:0]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [23:0] m;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'h0;
    m = {1'b0, d[51:29]} + {23'd0, d[28]};
    e = d[62:52] - 11'd896;
    if (m[23]) e = e + 11'd1;
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) - f2r(b));
  endfunction

  // Reference: magic estimate followed by it Newton steps, FP32 rounding per op.
  function automatic logic [31:0] ref_isqrt(input logic [31:0] x, input int it);
    logic [31:0] y, h, t;
    y = FP_MAGIC - (x >> 1);
    h = f_half(x);
    for (int i = 0; i < it; i++) begin
      t = fmul(y, y);
      t = fmul(h, t);
      t = fsub(32'h3FC00000, t);
      y = fmul(y, t);
    end
    return y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_tol(input string name, input logic [31:0] act, input logic [31:0] req,
                         input int tol);
    longint d;
    n_cmp++;
    d = (act > req) ? longint'(act - req) : longint'(req - act);
    if ($isunknown(act) || d > longint'(tol)) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (+/-%0d)", name, act, req, tol);
    end
  endtask

  // Init stage model: registered one cycle after init_data.
  always @(posedge clk) begin
    init_y     <= FP_MAGIC - (init_data >> 1);
    init_half  <= f_half(init_data);
    init_y0    <= FP_MAGIC - (init_data0 >> 1);
    init_half0 <= f_half(init_data0);
  end

  // FPU model, latency 2, with operand-routing checks.
  int          step = 0;
  int          dly = 0;
  logic [31:0] ym = '0, hm = '0, tm = '0, res_pend = '0;
  always @(negedge clk) begin
    fpu_done_m = 1'b0;
    if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        fpu_done_m = 1'b1;
        fpu_result = res_pend;
      end
    end
    if (rst) step = 0;
    if (!rst && in_valid && in_ready) begin
      step = 0;
      ym   = FP_MAGIC - (in_data >> 1);
      hm   = f_half(in_data);
    end
    if (fpu_valid) begin
      n_ops++;
      case (step)
        0: begin
          chk("sq_op", 32'(fpu_op), 32'(OP_MUL));
          chk("sq_a", fpu_a, ym);
          chk("sq_b", fpu_b, ym);
        end
        1: begin
          chk("hx_op", 32'(fpu_op), 32'(OP_MUL));
          chk("hx_a", fpu_a, hm);
          chk("hx_b", fpu_b, tm);
        end
        2: begin
          chk("sub_op", 32'(fpu_op), 32'(OP_RSUB));
          chk("sub_a", fpu_a, 32'h3FC00000);
          chk("sub_b", fpu_b, tm);
        end
        default: begin
          chk("upd_op", 32'(fpu_op), 32'(OP_MUL));
          chk("upd_a", fpu_a, ym);
          chk("upd_b", fpu_b, tm);
        end
      endcase
      res_pend = fpu_op ? fsub(fpu_a, fpu_b) : fmul(fpu_a, fpu_b);
      if (step == 3) ym = res_pend;
      else tm = res_pend;
      step = (step + 1) % 4;
      dly  = 2;
    end
  end

  // Output monitor: pops the scoreboard on every accepted result.
  always @(negedge clk) begin
    exp_t e;
    if (fpu_valid0) n_ops0++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %h, required no output", out_data);
      end else begin
        e = exp_q.pop_front();
        chk_tol("out_data", out_data, e.data, e.tol);
        chk("out_exc", 32'(out_exc), 32'(e.exc));
      end
    end
    if (!rst && out_valid0 && out_ready0) begin
      if (exp0_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out0: got %h, required no output", out_data0);
      end else begin
        e = exp0_q.pop_front();
        chk_tol("out_data0", out_data0, e.data, e.tol);
        chk("out_exc0", 32'(out_exc0), 32'(e.exc));
      end
    end
  end

  task automatic run_req(input logic [31:0] x, input logic [31:0] ed, input logic ee,
                         input int tol, input int elat);
    int lat;
    exp_q.push_back('{data: ed, exc: ee, tol: tol});
    in_data  = x;
    in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    @(posedge clk); #1;
    chk("out_valid_clear", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  logic [31:0] sp_x [0:6] = '{32'h00000000, 32'h80000000, 32'h00000001, 32'hC0800000,
                              32'h7F800000, 32'hFF800000, 32'h7FC00001};
  logic [31:0] sp_e [0:6] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h7FC00000,
                              32'h00000000, 32'h7FC00000, 32'h7FC00000};

  initial begin
    #500000;
    $display("FAIL watchdog: run still active, required completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    logic [31:0] held;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_init_data", init_data, 32'd0);
    chk("rst_fpu_valid", 32'(fpu_valid), 32'd0);
    chk("rst_in_ready0", 32'(in_ready0), 32'd1);

    // ITER=0: raw magic estimate after 3 cycles.
    exp0_q.push_back('{data: 32'h3EF759DF, exc: 1'b0, tol: 0});
    in_data0  = 32'h40800000;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    chk("init_data0", init_data0, 32'h40800000);
    lat = 1;
    while (!out_valid0 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency0", 32'(lat), 32'd3);
    @(posedge clk); #1;
    chk("busy0_clear", 32'(busy0), 32'd0);

    // ITER=2 with L=2: 3 + 2*4*3 = 27 cycles.
    run_req(32'h40800000, ref_isqrt(32'h40800000, 2), 1'b0, 8, 27);
    run_req(32'h3F800000, ref_isqrt(32'h3F800000, 2), 1'b0, 8, 27);

    foreach (sp_x[i]) begin
      base = n_ops;
      run_req(sp_x[i], sp_e[i], 1'b1, 0, 1);
      chk("special_no_fpu", 32'(n_ops), 32'(base));
    end

    // Spurious done in IDLE.
    held = out_data;
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    @(posedge clk); #1;
    chk("spur_idle_busy", 32'(busy), 32'd0);
    chk("spur_idle_out_valid", 32'(out_valid), 32'd0);
    chk("spur_idle_out_data", out_data, held);

    // Back-pressure in DONE while a new request waits.
    out_ready = 1'b0;
    exp_q.push_back('{data: ref_isqrt(32'h40800000, 2), exc: 1'b0, tol: 8});
    in_data  = 32'h40800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_latency", 32'(lat), 32'd27);
    held = out_data;
    exp_q.push_back('{data: ref_isqrt(32'h41800000, 2), exc: 1'b0, tol: 8});
    in_data  = 32'h41800000;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      spur_done = (c == 4);
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_data", out_data, held);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    spur_done = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("next_init_data", init_data, 32'h41800000);
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("next_latency", 32'(lat), 32'd27);
    @(posedge clk); #1;

    // Reset while HX op is pending.
    base = n_ops;
    in_data  = 32'h40800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (n_ops < base + 2 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("reach_hx", 32'(n_ops), 32'(base + 2));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", out_data, 32'd0);
    chk("abort_init_data", init_data, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("late_done_busy", 32'(busy), 32'd0);
    chk("late_done_out_valid", 32'(out_valid), 32'd0);
    run_req(32'h40800000, ref_isqrt(32'h40800000, 2), 1'b0, 8, 27);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size() + exp0_q.size()), 32'd0);
    chk("iter0_no_fpu", 32'(n_ops0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
